// File: rtl/spm_pipe_param_if.sv
// Handshake and result bus of the serial-parallel multiplier.
// The master drives the request (start and operands); the slave is the multiplier.
interface spm_pipe_param_if #(
  parameter int unsigned N = 8
) ();

  logic           start;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           tc;
  logic           busy;
  logic           p_bit;
  logic           p_valid;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, x, y, tc,
    input  busy, p_bit, p_valid, done, product
  );

  modport slave (
    input  start, x, y, tc,
    output busy, p_bit, p_valid, done, product
  );

endinterface

// File: rtl/spm_pipe_param.sv
// Serial-parallel multiplier built from N carry-save cells.
// x is held in parallel and y enters one bit per cycle, LSB first. Each RUN cycle emits one
// product bit, LSB first, for 2N cycles. The full 2N-bit product is then presented for one
// DONE cycle.
//
// Signed mode gives the x[N-1] column negative weight without adding any signed arithmetic.
// Each negative partial product is rewritten as -p*2^k = (~p)*2^k - 2^k. Summed over all
// 2N steps, the -2^k terms reduce to +2^(N-1) mod 2^(2N). That constant is preloaded into
// the top carry flop at acceptance. The chain then works entirely on non-negative values,
// so no sign extension of the carry-save state is ever required.
module spm_pipe_param #(
  parameter int unsigned N     = 8,
  parameter bit          TC_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  spm_pipe_param_if.slave   bus
);

  localparam int unsigned CntW = $clog2(2 * N) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * N - 1);
  localparam logic [CntW-1:0] YEnd    = CntW'(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [N-1:0]     x_q;
  logic [N-1:0]     y_q;
  logic             tc_q;
  logic [CntW-1:0]  cnt_q;
  // Cell j's stored sum feeds cell j-1 on the next step, so cell 0's sum is never stored.
  logic [N-1:1]     sum_q;
  logic [N-1:0]     carry_q;
  // Earlier product bits; the final bit is merged in directly when product is loaded.
  logic [2*N-2:0]   sr_q;
  logic [2*N-1:0]   product_q;
  logic             busy_q;
  logic             p_valid_q;
  logic             done_q;

  logic             tc_eff;
  logic             y_bit;
  logic [N-1:0]     pp;
  logic [N-1:0]     sum_in;
  logic [N-1:0]     sum_d;
  logic [N-1:0]     carry_d;

  assign tc_eff = bus.tc & TC_EN;

  // Multiplier bit for the current step, sign-extended past the top of y in signed mode.
  always_comb begin
    y_bit = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (cnt_q == CntW'(j)) begin
        y_bit = y_q[j];
      end
    end
    if (cnt_q >= YEnd) begin
      y_bit = tc_q & y_q[N-1];
    end
  end

  // One carry-save step: each cell adds its partial product, the shifted-down sum and its carry.
  always_comb begin
    pp          = x_q & {N{y_bit}};
    pp[N-1]     = pp[N-1] ^ tc_q;
    sum_in      = {1'b0, sum_q};
    sum_d       = pp ^ sum_in ^ carry_q;
    carry_d     = (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);
  end

  // Control FSM plus datapath state; all outputs except p_bit are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      tc_q      <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      sr_q      <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      p_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            x_q       <= bus.x;
            y_q       <= bus.y;
            tc_q      <= tc_eff;
            cnt_q     <= '0;
            sum_q     <= '0;
            carry_q   <= {tc_eff, {(N - 1){1'b0}}};
            state_q   <= StRun;
            busy_q    <= 1'b1;
            p_valid_q <= 1'b1;
          end
        end
        StRun: begin
          sum_q   <= sum_d[N-1:1];
          carry_q <= carry_d;
          sr_q    <= {sum_d[0], sr_q[2*N-2:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            product_q <= {sum_d[0], sr_q};
            state_q   <= StDone;
            p_valid_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.p_valid = p_valid_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  // The serial bit is the cell-0 sum of the step happening in this cycle.
  assign bus.p_bit   = (state_q == StRun) & sum_d[0];

endmodule

// File: doc/spm_pipe_param.md
SPM_PIPE_PARAM -- requirements
Module: spm_pipe_param

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter TC_EN, default 1: 1 means two's-complement mode is selectable via tc; 0 forces unsigned and ignores tc.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-005 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-006 SHALL have port x  input  N  parallel multiplicand; captured on start acceptance.
REQ-007 SHALL have port y  input  N  multiplier; captured on start acceptance and fed LSB-first into the carry-save chain.
REQ-008 SHALL have port tc  input  1  1 means signed operands; captured on start acceptance.
REQ-009 SHALL have port busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port p_bit  output  1  serial product bit, LSB first.
REQ-011 SHALL have port p_valid  output  1  qualifies p_bit.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port product  output  2N  full product register.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept start when state is IDLE and start=1 (cycle 0): latch x, y and tc (effective tc = tc AND TC_EN), clear the CSA sum/carry flops, load the bit counter with 0, and move to RUN.
REQ-016 SHALL in RUN run one serial step per cycle through N carry-save cells: one y bit enters, the counter increments, and one product bit is emitted.
REQ-017 SHALL feed y bit i during step i for i<N; for steps i>=N it SHALL feed y[N-1] when tc=1 and 0 when tc=0.
REQ-018 SHALL assert p_valid during RUN cycles 1..2N after acceptance, with p_bit equal to bit (cycle-1) of the result.
REQ-019 SHALL define the result as (x*y) mod 2^(2N), with x and y signed when tc=1 and unsigned when tc=0.
REQ-020 SHALL give the x[N-1] cell negative partial-product weight when tc=1, so the signed result is exact.
REQ-021 SHALL shift each p_bit into an internal 2N-bit shift register.
REQ-022 SHALL go from RUN to DONE after the step with counter value 2N-1 (cycle 2N).
REQ-023 SHALL, in cycle 2N+1, be in DONE with done=1, update product from the shift register, and keep busy=1 and p_valid=0.
REQ-024 SHALL go from DONE to IDLE unconditionally after one cycle.
REQ-025 SHALL hold product unchanged until the next DONE.
REQ-026 SHALL ignore start in RUN and DONE without queuing it, and SHALL leave the latched operands unchanged.
REQ-027 SHALL, when start is held high continuously, accept it in the IDLE cycle after each DONE, giving a period of 2N+2 cycles.
REQ-028 SHALL have no effect on an operation in progress from changes on x, y or tc after acceptance.
REQ-029 SHALL size the bit counter to ceil(log2(2N))+1 bits with no wrap within an operation.

Reset
REQ-030 SHALL, on rst=0, set state to IDLE, set busy=0, p_bit=0, p_valid=0, done=0 and product=0, and clear the counter, CSA flops, shift register and latched operands.
REQ-031 SHALL abandon an operation when reset is asserted mid-RUN or mid-DONE, with no done pulse and product=0.
REQ-032 SHALL allow the first start acceptance in the first rising edge after rst is released, when start=1.

Verification (N=8 unless stated)
REQ-033 SHALL be checked with: tc=0, x=0xFF, y=0xFF -> done at cycle 17 with product=0xFE01, and p_bit sequence LSB-first matching 0xFE01 over cycles 1..16.
REQ-034 SHALL be checked with: tc=1, x=0x80, y=0x80 (-128*-128) -> product=0x4000; and tc=1, x=0xFF, y=0x01 -> product=0xFFFF.
REQ-035 SHALL be checked with: tc=0, x=0x00, y=0xA5 -> product=0x0000, with p_valid high for exactly 16 cycles.
REQ-036 SHALL be checked with: rst=0 asserted at cycle 5 of RUN -> busy, p_valid, done and product all 0 immediately; the next start (x=3, y=5) -> product=0x000F.
REQ-037 SHALL be checked with: start held high for 3 operations -> done pulses exactly 18 cycles apart; start pulsed during RUN -> ignored, with a single done.
REQ-038 SHALL be checked with: TC_EN=0, tc=1, x=0xFF, y=0xFF -> product=0xFE01 (unsigned); and N=16, TC_EN=1, tc=1, x=0x8000, y=0x7FFF -> product=0xC0008000.
